victory_scoreboard: RTL and testbench
=====================================

# victory_scoreboard

Match-level successor to the single-round victory display for the tug-of-war game. It detects round wins from the playfield edge lights and player presses, and keeps a per-player score up to a parametrised match length. It drives two active-low seven-segment digits, pulses a round-reset to restart the playfield, and latches a match winner. It sits between the playfield light chain and the HEX displays.

## Interface
- `WIN_SCORE`, default 7: rounds needed to win the match; legal range 1..9.
- `HOLD_CYCLES`, default 4: cycles `round_reset` is held after each non-final round win; legal range ≥1.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `L` in 1: left player press (synchronized, single-cycle pulse).
- `R` in 1: right player press (synchronized, single-cycle pulse).
- `L_fin` in 1: leftmost playfield light is lit.
- `R_fin` in 1: rightmost playfield light is lit.
- `HEX0` out 7: right player score digit, active-low segments.
- `HEX5` out 7: left player score digit, active-low segments.
- `round_reset` out 1: playfield restart request.
- `match_over` out 1: a player has reached `WIN_SCORE`.
- `winner` out 2: 2'b10 left, 2'b01 right, 2'b00 none.

## Operation
- Left round win: `L & ~R & L_fin`. Right round win: `R & ~L & R_fin`.
- `L & R` together is never a win, regardless of the fin inputs.
- Both fins high with a single press: only the pressing side's rule applies.
- FSM states and transitions:
  - PLAY: on a win, increment that player's score.
    - If the new score equals `WIN_SCORE`, go to MATCH_OVER.
    - Otherwise go to HOLD and load the hold counter with `HOLD_CYCLES-1`.
  - HOLD: `round_reset`=1. Presses are ignored. The counter decrements each cycle; at 0 return to PLAY.
  - MATCH_OVER: `round_reset`=1, `match_over`=1, `winner` set. All inputs are ignored until `reset`.
- Score width is `$clog2(WIN_SCORE+1)`. Scores never exceed `WIN_SCORE`; no wrap.
- Digit encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset values:
  - state PLAY, both scores 0
  - `HEX0`=`HEX5`=1000000
  - `round_reset`=0, `match_over`=0, `winner`=2'b00
- Reset asserted mid-HOLD or in MATCH_OVER returns immediately to the reset values; no residual `round_reset`.

## Timing
- Inputs are sampled at a rising edge.
- A win sampled at edge n:
  - score and HEX update after edge n;
  - `round_reset` is high for exactly `HOLD_CYCLES` cycles following edge n;
  - the first press that can score is sampled at edge n+`HOLD_CYCLES`+1.
- Final win at edge n: `match_over`, `winner` and `round_reset` rise after edge n and stay high.
- All outputs are combinational decodes of registered state only; there is no input-to-output combinational path.
- `reset` acts asynchronously on assertion. Deassertion is assumed synchronous to `clk` from the board-level synchronizer.

## Structure
- Package `victory_pkg` holds:
  - the FSM state enum `{PLAY, HOLD, MATCH_OVER}`;
  - the `winner` encodings `WIN_NONE`, `WIN_L`, `WIN_R`;
  - the 10-entry seven-segment constant array.
- Sub-module `seg7_digit` (4-bit value in, 7-bit active-low out; values >9 give all-off 1111111) is instantiated twice.
- The top holds the FSM, two score registers and the hold counter.
- Elaboration-time assertions check the parameter ranges.

## Test plan
- Reset then idle 20 cycles: `HEX0`=`HEX5`=1000000, `round_reset`=0, `winner`=00.
- `L_fin`=1 with an `L` pulse (`HOLD_CYCLES`=4):
  - `HEX5`=1111001, `round_reset` high for exactly 4 cycles;
  - an `L` pulse during the hold leaves the score at 1.
- `L`=`R`=1 with both fins high: no score change, no `round_reset`.
- `WIN_SCORE`=3, three right wins spaced past the hold:
  - `HEX0`=0110000, `match_over`=1, `winner`=01, `round_reset` stays high;
  - a further `R`/`R_fin` pulse changes nothing.
- Assert `reset` in the second HOLD cycle: all outputs return to reset values within the same cycle, asynchronously.
- Alternate left and right wins to 2-2 with `WIN_SCORE`=3, then a left win: `HEX5`=0110000, `HEX0`=0100100, `winner`=10.

Source files
------------

// File: rtl/victory_pkg.sv
// Shared types and constants for the tug-of-war match scoreboard.
package victory_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b10;
  localparam logic [1:0] WIN_R    = 2'b01;

  // Active-low gfedcba patterns for digits 0..9
  localparam logic [6:0] SEG7_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/seg7_digit.sv
// Single decimal digit to active-low seven-segment decode; out-of-range blanks.
module seg7_digit
  import victory_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    if (value <= 4'd9) seg = SEG7_TABLE[value];
  end

endmodule

// File: rtl/victory_scoreboard.sv
// Match-level scoreboard: detects round wins, keeps per-player scores,
// holds the playfield in reset between rounds and latches the match winner.
//
// state      | meaning
// PLAY       | round in progress, presses can score
// HOLD       | round just won, playfield held in reset for HOLD_CYCLES
// MATCH_OVER | a player reached WIN_SCORE, frozen until reset
module victory_scoreboard
  import victory_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       L_fin,
  input  logic       R_fin,
  output logic [6:0] HEX0,
  output logic [6:0] HEX5,
  output logic       round_reset,
  output logic       match_over,
  output logic [1:0] winner
);

  localparam int SW = $clog2(WIN_SCORE + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SW-1:0] SCORE_MAX = SW'(WIN_SCORE);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win_score
    $error("victory_scoreboard: WIN_SCORE must be in 1..9");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("victory_scoreboard: HOLD_CYCLES must be at least 1");
  end

  state_t        state;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic [HW-1:0] hold_cnt;

  logic          win_l;
  logic          win_r;
  logic [SW-1:0] next_l;
  logic [SW-1:0] next_r;

  // Simultaneous presses cancel out, whatever the fin lights show
  assign win_l  = L & ~R & L_fin;
  assign win_r  = R & ~L & R_fin;
  assign next_l = score_l + SW'(1);
  assign next_r = score_r + SW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      score_l  <= '0;
      score_r  <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        PLAY: begin
          if (win_l) begin
            score_l <= next_l;
            if (next_l == SCORE_MAX) begin
              state <= MATCH_OVER;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end else if (win_r) begin
            score_r <= next_r;
            if (next_r == SCORE_MAX) begin
              state <= MATCH_OVER;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= PLAY;
          else                hold_cnt <= hold_cnt - HW'(1);
        end
        MATCH_OVER: state <= MATCH_OVER;
        default:    state <= PLAY;
      endcase
    end
  end

  assign round_reset = (state != PLAY);
  assign match_over  = (state == MATCH_OVER);

  // Whoever sits at the cap is the winner; only one side can get there
  always_comb begin
    winner = WIN_NONE;
    if (match_over) winner = (score_l == SCORE_MAX) ? WIN_L : WIN_R;
  end

  seg7_digit u_digit_r (
    .value (4'(score_r)),
    .seg   (HEX0)
  );

  seg7_digit u_digit_l (
    .value (4'(score_l)),
    .seg   (HEX5)
  );

endmodule

// File: tb/tb_victory_scoreboard.sv
// Self-checking bench for victory_scoreboard with WIN_SCORE=3, HOLD_CYCLES=4.
module tb_victory_scoreboard;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;

  typedef struct {
    logic       l, r, lf, rf;
    logic [6:0] hex0, hex5;
    logic       rr, mo;
    logic [1:0] win;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       L = 1'b0, R = 1'b0, L_fin = 1'b0, R_fin = 1'b0;
  logic [6:0] HEX0, HEX5;
  logic       round_reset, match_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  vec_t exp_q[$];
  vec_t tbl[25];

  always #5 clk = ~clk;

  victory_scoreboard #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R), .L_fin(L_fin), .R_fin(R_fin),
    .HEX0(HEX0), .HEX5(HEX5), .round_reset(round_reset),
    .match_over(match_over), .winner(winner)
  );

  function automatic vec_t mk(logic l, logic r, logic lf, logic rf,
                              logic [6:0] h0, logic [6:0] h5,
                              logic rr, logic mo, logic [1:0] w);
    vec_t v;
    v.l = l; v.r = r; v.lf = lf; v.rf = rf;
    v.hex0 = h0; v.hex5 = h5; v.rr = rr; v.mo = mo; v.win = w;
    return v;
  endfunction

  task automatic cmp(string name, int idx, logic [6:0] act, logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, req);
    end
  endtask

  task automatic check_outputs(string tag, int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s step %0d: scoreboard empty, got 1 expected 0", tag, idx);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".HEX0"}, idx, HEX0, e.hex0);
    cmp({tag, ".HEX5"}, idx, HEX5, e.hex5);
    cmp({tag, ".round_reset"}, idx, {6'b0, round_reset}, {6'b0, e.rr});
    cmp({tag, ".match_over"}, idx, {6'b0, match_over}, {6'b0, e.mo});
    cmp({tag, ".winner"}, idx, {5'b0, winner}, {5'b0, e.win});
  endtask

  // Drive one vector on the falling edge, sample just after the next rising edge
  task automatic step(string tag, int idx, vec_t v);
    @(negedge clk);
    L = v.l; R = v.r; L_fin = v.lf; R_fin = v.rf;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_outputs(tag, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    L = 0; R = 0; L_fin = 0; R_fin = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Table: left win, hold, boundary press, tie, then alternate to 2-2 and left takes the match
    tbl[0]  = mk(1,0,1,0, S0,S1, 1,0,2'b00);
    tbl[1]  = mk(1,0,1,0, S0,S1, 1,0,2'b00);
    tbl[2]  = mk(0,0,0,0, S0,S1, 1,0,2'b00);
    tbl[3]  = mk(0,0,0,0, S0,S1, 1,0,2'b00);
    tbl[4]  = mk(0,1,0,1, S0,S1, 0,0,2'b00);
    tbl[5]  = mk(1,1,1,1, S0,S1, 0,0,2'b00);
    tbl[6]  = mk(0,1,1,0, S0,S1, 0,0,2'b00);
    tbl[7]  = mk(1,0,1,1, S0,S2, 1,0,2'b00);
    tbl[8]  = mk(0,0,0,0, S0,S2, 1,0,2'b00);
    tbl[9]  = mk(0,0,0,0, S0,S2, 1,0,2'b00);
    tbl[10] = mk(0,0,0,0, S0,S2, 1,0,2'b00);
    tbl[11] = mk(0,0,0,0, S0,S2, 0,0,2'b00);
    tbl[12] = mk(0,1,1,1, S1,S2, 1,0,2'b00);
    tbl[13] = mk(0,0,0,0, S1,S2, 1,0,2'b00);
    tbl[14] = mk(0,0,0,0, S1,S2, 1,0,2'b00);
    tbl[15] = mk(0,0,0,0, S1,S2, 1,0,2'b00);
    tbl[16] = mk(0,0,0,0, S1,S2, 0,0,2'b00);
    tbl[17] = mk(0,1,0,1, S2,S2, 1,0,2'b00);
    tbl[18] = mk(0,0,0,0, S2,S2, 1,0,2'b00);
    tbl[19] = mk(0,0,0,0, S2,S2, 1,0,2'b00);
    tbl[20] = mk(0,0,0,0, S2,S2, 1,0,2'b00);
    tbl[21] = mk(0,0,0,0, S2,S2, 0,0,2'b00);
    tbl[22] = mk(1,0,1,0, S2,S3, 1,1,2'b10);
    tbl[23] = mk(0,1,0,1, S2,S3, 1,1,2'b10);
    tbl[24] = mk(1,0,1,0, S2,S3, 1,1,2'b10);

    do_reset();
    for (int i = 0; i < 20; i++)
      step("idle", i, mk(0,0,0,0, S0,S0, 0,0,2'b00));

    for (int i = 0; i < 25; i++)
      step("table", i, tbl[i]);

    // Asynchronous reset in the second hold cycle
    do_reset();
    step("async", 0, mk(1,0,1,0, S0,S1, 1,0,2'b00));
    step("async", 1, mk(0,0,0,0, S0,S1, 1,0,2'b00));
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(0,0,0,0, S0,S0, 0,0,2'b00));
    check_outputs("async_rst", 2);
    @(negedge clk);
    reset = 1'b0;
    step("async", 3, mk(0,0,0,0, S0,S0, 0,0,2'b00));

    // Three right wins spaced past the hold, then a stray press after the match
    for (int k = 1; k <= 3; k++) begin
      logic [6:0] h0;
      h0 = (k == 1) ? S1 : (k == 2) ? S2 : S3;
      if (k < 3) begin
        step("right", k*10,   mk(0,1,0,1, h0,S0, 1,0,2'b00));
        step("right", k*10+1, mk(0,0,0,0, h0,S0, 1,0,2'b00));
        step("right", k*10+2, mk(0,0,0,0, h0,S0, 1,0,2'b00));
        step("right", k*10+3, mk(0,0,0,0, h0,S0, 1,0,2'b00));
        step("right", k*10+4, mk(0,0,0,0, h0,S0, 0,0,2'b00));
      end else begin
        step("right", k*10, mk(0,1,0,1, h0,S0, 1,1,2'b01));
      end
    end
    step("frozen", 0, mk(0,1,0,1, S3,S0, 1,1,2'b01));
    for (int i = 1; i < 8; i++)
      step("frozen", i, mk(0,0,0,0, S3,S0, 1,1,2'b01));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
